// File: rtl/averager_scheduler_pkg.sv
// Shared definitions for the averager scheduler: FSM states, readout FIFO sizing
// and the index-to-byte-address shift.
package averager_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_BUSY,
        ST_WAIT_READY,
        ST_READOUT,
        ST_DONE
    } state_e;

    localparam int FIFO_SLACK = 2;
    localparam int ADDR_SHIFT = 2;

    // Enough room for every read in flight through the BRAM plus slack for full rate.
    function automatic int fifo_depth(input int bram_latency);
        return bram_latency + FIFO_SLACK;
    endfunction

endpackage

// File: rtl/averager_readout_fifo.sv
// Small synchronous FIFO between the BRAM read pipeline and the output stream;
// its occupancy count feeds the read-credit logic in the scheduler.
module averager_readout_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rptr_q];
    assign count   = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + CW'(do_wr) - CW'(do_rd);
        if (do_wr) begin
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (do_rd) begin
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/averager_scheduler.sv
// Sequences one averager frame: restart the counter, wait for it to finish,
// then stream the accumulation BRAM out over AXI4-Stream with backpressure.
module averager_scheduler
    import averager_scheduler_pkg::*;
#(
    parameter int FAST_COUNT_WIDTH = 13,
    parameter int SLOW_COUNT_WIDTH = 19,
    parameter int DATA_WIDTH       = 32,
    parameter int BRAM_LATENCY     = 2,
    parameter int TIMEOUT_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          continuous,
    input  logic [FAST_COUNT_WIDTH-1:0]   count_max,
    input  logic [TIMEOUT_WIDTH-1:0]      timeout_cycles,
    output logic                          avg_restart,
    input  logic                          avg_ready,
    input  logic [SLOW_COUNT_WIDTH-1:0]   avg_n_avg,
    output logic                          bram_en,
    output logic [FAST_COUNT_WIDTH+1:0]   bram_addr,
    input  logic [DATA_WIDTH-1:0]         bram_rdata,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic [SLOW_COUNT_WIDTH-1:0]   n_avg,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [31:0]                   frame_count
);

    localparam int DEPTH = fifo_depth(BRAM_LATENCY);
    localparam int CW    = $clog2(DEPTH + 1);

    state_e                        state_q, state_d;
    logic [FAST_COUNT_WIDTH-1:0]   count_max_q, count_max_d;
    logic [FAST_COUNT_WIDTH-1:0]   rd_idx_q, rd_idx_d;
    logic                          rd_done_q, rd_done_d;
    logic [SLOW_COUNT_WIDTH-1:0]   n_avg_q, n_avg_d;
    logic                          error_q, error_d;
    logic                          stop_req_q, stop_req_d;
    logic [31:0]                   frame_count_q, frame_count_d;
    logic [TIMEOUT_WIDTH-1:0]      timer_q, timer_d;
    logic [BRAM_LATENCY-1:0]       vpipe_q, vpipe_d, lpipe_q, lpipe_d;

    logic [CW-1:0]                 inflight, fifo_count;
    logic [CW:0]                   credit_used;
    logic [DATA_WIDTH:0]           fifo_rdata;
    logic                          fifo_empty, fifo_pop, rd_fire, rd_last, timeout_hit;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            inflight = inflight + CW'(vpipe_q[i]);
        end
    end

    // A read is only issued if its word is guaranteed a FIFO slot on return.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign rd_last     = (rd_idx_q == count_max_q);
    assign rd_fire     = (state_q == ST_READOUT) && !rd_done_q && (credit_used < (CW + 1)'(DEPTH));
    assign fifo_pop    = !fifo_empty && m_tready;
    assign timeout_hit = (timeout_cycles != '0) &&
                         ((timer_q + TIMEOUT_WIDTH'(1)) == timeout_cycles);

    always_comb begin
        vpipe_d[0] = rd_fire;
        lpipe_d[0] = rd_last;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            lpipe_d[i] = lpipe_q[i-1];
        end
    end

    always_comb begin
        state_d       = state_q;
        count_max_d   = count_max_q;
        rd_idx_d      = rd_idx_q;
        rd_done_d     = rd_done_q;
        n_avg_d       = n_avg_q;
        error_d       = error_q;
        stop_req_d    = stop_req_q;
        frame_count_d = frame_count_q;
        timer_d       = timer_q;

        if (stop && (state_q != ST_IDLE)) begin
            stop_req_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_max_d = count_max;
                    error_d     = 1'b0;
                    stop_req_d  = 1'b0;
                    state_d     = ST_ARM;
                end
            end
            ST_ARM: begin
                timer_d = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!avg_ready) begin
                    timer_d = '0;
                    state_d = ST_WAIT_READY;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMEOUT_WIDTH'(1);
                end
            end
            ST_WAIT_READY: begin
                if (avg_ready) begin
                    n_avg_d   = avg_n_avg;
                    rd_idx_d  = '0;
                    rd_done_d = 1'b0;
                    state_d   = ST_READOUT;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMEOUT_WIDTH'(1);
                end
            end
            ST_READOUT: begin
                if (rd_fire) begin
                    if (rd_last) begin
                        rd_done_d = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
                if (fifo_pop && fifo_rdata[DATA_WIDTH]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_count_d = frame_count_q + 32'd1;
                state_d       = (continuous && !stop_req_q) ? ST_ARM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            count_max_q   <= '0;
            rd_idx_q      <= '0;
            rd_done_q     <= 1'b0;
            n_avg_q       <= '0;
            error_q       <= 1'b0;
            stop_req_q    <= 1'b0;
            frame_count_q <= '0;
            timer_q       <= '0;
            vpipe_q       <= '0;
            lpipe_q       <= '0;
        end else begin
            state_q       <= state_d;
            count_max_q   <= count_max_d;
            rd_idx_q      <= rd_idx_d;
            rd_done_q     <= rd_done_d;
            n_avg_q       <= n_avg_d;
            error_q       <= error_d;
            stop_req_q    <= stop_req_d;
            frame_count_q <= frame_count_d;
            timer_q       <= timer_d;
            vpipe_q       <= vpipe_d;
            lpipe_q       <= lpipe_d;
        end
    end

    averager_readout_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .wr_en   (vpipe_q[BRAM_LATENCY-1]),
        .wr_data ({lpipe_q[BRAM_LATENCY-1], bram_rdata}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign avg_restart = (state_q == ST_ARM);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign bram_en     = rd_fire;
    assign bram_addr   = {rd_idx_q, {ADDR_SHIFT{1'b0}}};
    assign m_tvalid    = !fifo_empty;
    assign m_tdata     = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH-1:0];
    assign m_tlast     = !fifo_empty && fifo_rdata[DATA_WIDTH];
    assign n_avg       = n_avg_q;
    assign error       = error_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_averager_scheduler.sv
// Directed bench for averager_scheduler: table of single-shot frames plus
// hand-written continuous, timeout, start-ignore and mid-frame reset sequences.
module tb_averager_scheduler;

    localparam int FW  = 13;
    localparam int SW  = 19;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int TW  = 32;

    logic           clk;
    logic           aresetn;
    logic           start, stop, continuous;
    logic [FW-1:0]  count_max;
    logic [TW-1:0]  timeout_cycles;
    logic           avg_restart, avg_ready;
    logic [SW-1:0]  avg_n_avg;
    logic           bram_en;
    logic [FW+1:0]  bram_addr;
    logic [DW-1:0]  bram_rdata;
    logic [DW-1:0]  m_tdata;
    logic           m_tvalid, m_tready, m_tlast;
    logic [SW-1:0]  n_avg;
    logic           busy, done, error;
    logic [31:0]    frame_count;

    int checks = 0;
    int failures = 0;
    int beat_cnt = 0;
    int restart_cnt = 0;
    int done_cnt = 0;
    int stall_pct = 0;
    int model_navg = 0;
    bit never_drop = 0;
    int exp_frames = 0;
    logic [FW-1:0] exp_cm = '0;
    logic [FW-1:0] exp_idx = '0;
    bit            stalled = 0;
    logic [DW-1:0] held_data;
    logic          held_last;
    logic [DW-1:0] bram_pipe [LAT];

    typedef struct {
        logic [FW-1:0] cm;
        int            stall;
        int            navg;
        int            exp_beats;
        int            exp_navg;
    } vec_t;

    vec_t vecs [5];

    averager_scheduler dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .start          (start),
        .stop           (stop),
        .continuous     (continuous),
        .count_max      (count_max),
        .timeout_cycles (timeout_cycles),
        .avg_restart    (avg_restart),
        .avg_ready      (avg_ready),
        .avg_n_avg      (avg_n_avg),
        .bram_en        (bram_en),
        .bram_addr      (bram_addr),
        .bram_rdata     (bram_rdata),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .n_avg          (n_avg),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .frame_count    (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memval(input logic [FW-1:0] idx);
        return {3'b101, idx, 3'b010, ~idx};
    endfunction

    // BRAM model: fixed read latency of LAT clocks from en/addr to rdata.
    always @(posedge clk) begin
        if (bram_en) bram_pipe[0] <= memval(bram_addr[FW+1:2]);
        for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign bram_rdata = bram_pipe[LAT-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Averager counter model: ready drops 2 cycles after restart, returns 40 later.
    initial begin
        avg_ready = 1'b1;
        avg_n_avg = '0;
        forever begin
            @(negedge clk);
            if (avg_restart && aresetn) begin
                repeat (2) @(negedge clk);
                if (!never_drop) begin
                    avg_ready = 1'b0;
                    repeat (40) @(negedge clk);
                    avg_n_avg = SW'(model_navg);
                    avg_ready = 1'b1;
                end
            end
        end
    end

    // Stream sink and event counters; beats are checked against the BRAM contents.
    always @(negedge clk) begin
        if (!aresetn) begin
            stalled = 0;
        end else begin
            m_tready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            if (avg_restart) restart_cnt++;
            if (done) done_cnt++;
            if (stalled) begin
                checkOutput("stall_valid", m_tvalid, 1);
                checkOutput("stall_data", m_tdata, held_data);
                checkOutput("stall_last", m_tlast, held_last);
            end
            if (m_tvalid && m_tready) begin
                checkOutput("beat_data", m_tdata, memval(exp_idx));
                checkOutput("beat_last", m_tlast, exp_idx == exp_cm);
                beat_cnt++;
                exp_idx = (exp_idx == exp_cm) ? '0 : exp_idx + 1'b1;
                stalled = 0;
            end else if (m_tvalid) begin
                stalled   = 1;
                held_data = m_tdata;
                held_last = m_tlast;
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [FW-1:0] cm, input int navg);
        model_navg  = navg;
        count_max   = cm;
        exp_cm      = cm;
        exp_idx     = '0;
        beat_cnt    = 0;
        restart_cnt = 0;
        done_cnt    = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        count_max = cm ^ 13'h0155;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_restart", avg_restart, 1);
    endtask

    task automatic waitIdle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle", busy, 0);
        @(negedge clk);
    endtask

    task automatic waitBeats(input int target, input int max_cycles);
        int n = 0;
        while (beat_cnt < target && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_beats", beat_cnt >= target, 1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{cm: 13'd7,  stall: 0,  navg: 5,      exp_beats: 8,  exp_navg: 5};
        vecs[1] = '{cm: 13'd15, stall: 30, navg: 9,      exp_beats: 16, exp_navg: 9};
        vecs[2] = '{cm: 13'd0,  stall: 0,  navg: 1,      exp_beats: 1,  exp_navg: 1};
        vecs[3] = '{cm: 13'd3,  stall: 50, navg: 524287, exp_beats: 4,  exp_navg: 524287};
        vecs[4] = '{cm: 13'd40, stall: 20, navg: 1000,   exp_beats: 41, exp_navg: 1000};

        aresetn        = 1'b0;
        start          = 1'b0;
        stop           = 1'b0;
        continuous     = 1'b0;
        count_max      = '0;
        timeout_cycles = '0;
        m_tready       = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_restart", avg_restart, 0);
        checkOutput("rst_bram_en", bram_en, 0);
        checkOutput("rst_bram_addr", bram_addr, 0);
        checkOutput("rst_tvalid", m_tvalid, 0);
        checkOutput("rst_tlast", m_tlast, 0);
        checkOutput("rst_tdata", m_tdata, 0);
        checkOutput("rst_n_avg", n_avg, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_frame_count", frame_count, 0);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            stall_pct = vecs[v].stall;
            applyStimulus(vecs[v].cm, vecs[v].navg);
            waitIdle(3000);
            exp_frames++;
            $display("[TB] vector %0d count_max=%0d beats=%0d", v, vecs[v].cm, beat_cnt);
            checkOutput("vec_beats", beat_cnt, vecs[v].exp_beats);
            checkOutput("vec_restarts", restart_cnt, 1);
            checkOutput("vec_dones", done_cnt, 1);
            checkOutput("vec_n_avg", n_avg, vecs[v].exp_navg);
            checkOutput("vec_frame_count", frame_count, exp_frames);
            checkOutput("vec_error", error, 0);
            checkOutput("vec_tvalid_idle", m_tvalid, 0);
        end
        stall_pct = 0;

        // Continuous mode, stop during the second frame's WAIT_READY.
        continuous = 1'b1;
        applyStimulus(13'd5, 33);
        for (int n = 0; n < 500 && restart_cnt < 2; n++) @(negedge clk);
        checkOutput("cont_second_restart", restart_cnt, 2);
        repeat (10) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        waitIdle(2000);
        continuous = 1'b0;
        exp_frames += 2;
        checkOutput("cont_beats", beat_cnt, 12);
        checkOutput("cont_restarts", restart_cnt, 2);
        checkOutput("cont_dones", done_cnt, 2);
        checkOutput("cont_frame_count", frame_count, exp_frames);
        checkOutput("cont_n_avg", n_avg, 33);

        // Timeout in WAIT_BUSY: counter never drops ready.
        never_drop     = 1;
        timeout_cycles = 32'd100;
        applyStimulus(13'd3, 2);
        repeat (85) @(negedge clk);
        checkOutput("to_not_early", error, 0);
        checkOutput("to_still_busy", busy, 1);
        waitIdle(100);
        checkOutput("to_error", error, 1);
        checkOutput("to_no_beats", beat_cnt, 0);
        checkOutput("to_no_done", done_cnt, 0);
        checkOutput("to_frame_count", frame_count, exp_frames);
        never_drop = 0;
        applyStimulus(13'd2, 17);
        checkOutput("to_error_cleared", error, 0);
        waitIdle(2000);
        exp_frames++;
        checkOutput("to_retry_beats", beat_cnt, 3);
        checkOutput("to_retry_error", error, 0);
        checkOutput("to_retry_frame_count", frame_count, exp_frames);
        timeout_cycles = '0;

        // Start pulsed during READOUT must be ignored.
        applyStimulus(13'd31, 4);
        waitBeats(1, 200);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle(2000);
        exp_frames++;
        checkOutput("ign_restarts", restart_cnt, 1);
        checkOutput("ign_beats", beat_cnt, 32);
        checkOutput("ign_dones", done_cnt, 1);
        checkOutput("ign_frame_count", frame_count, exp_frames);

        // Asynchronous reset in the middle of READOUT, then a fresh frame.
        applyStimulus(13'd15, 6);
        waitBeats(3, 200);
        aresetn = 1'b0;
        #1;
        checkOutput("mid_rst_tvalid", m_tvalid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_bram_en", bram_en, 0);
        checkOutput("mid_rst_tdata", m_tdata, 0);
        checkOutput("mid_rst_tlast", m_tlast, 0);
        checkOutput("mid_rst_n_avg", n_avg, 0);
        checkOutput("mid_rst_frame_count", frame_count, 0);
        exp_frames = 0;
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_tvalid", m_tvalid, 0);
        applyStimulus(13'd4, 8);
        waitIdle(2000);
        exp_frames++;
        checkOutput("post_rst_beats", beat_cnt, 5);
        checkOutput("post_rst_n_avg", n_avg, 8);
        checkOutput("post_rst_frame_count", frame_count, exp_frames);
        checkOutput("post_rst_dones", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/averager_scheduler.md
# averager_scheduler

Sequencer for one averager counter and its accumulation BRAM. On a software start it pulses the counter's restart, waits for the averaging frame to complete, latches the number of averages, then streams the BRAM contents (addresses 0..count_max) to a downstream AXI4-Stream consumer with full backpressure support. It sits between the config/status register bank, the averager counter and the DMA/stream path, and optionally re-arms continuously.

## Interface
- FAST_COUNT_WIDTH, 13: width of the bin index and of `count_max`
- SLOW_COUNT_WIDTH, 19: width of the averages count
- DATA_WIDTH, 32: BRAM word / stream width
- BRAM_LATENCY, 2: cycles from `bram_en`+`bram_addr` to valid `bram_rdata`
- TIMEOUT_WIDTH, 32: width of the timeout counter

Ports:
- clk  in  1  single clock for all logic
- aresetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, begins acquisition
- stop  in  1  one-cycle pulse, ends continuous mode after the current frame
- continuous  in  1  re-arm automatically after each frame
- count_max  in  FAST_COUNT_WIDTH  last bin index, sampled at start
- timeout_cycles  in  TIMEOUT_WIDTH  max cycles per wait state; 0 disables
- avg_restart  out  1  restart pulse to averager counter
- avg_ready  in  1  counter ready flag
- avg_n_avg  in  SLOW_COUNT_WIDTH  counter averages result
- bram_en  out  1  BRAM read enable
- bram_addr  out  FAST_COUNT_WIDTH+2  byte address, {index, 2'b00}
- bram_rdata  in  DATA_WIDTH  BRAM read data
- m_tdata  out  DATA_WIDTH, m_tvalid  out  1, m_tready  in  1, m_tlast  out  1  output stream
- n_avg  out  SLOW_COUNT_WIDTH  averages of last completed frame
- busy  out  1, done  out  1 (pulse), error  out  1 (sticky), frame_count  out  32

## Operation
- States: IDLE, ARM, WAIT_BUSY, WAIT_READY, READOUT, DONE.
- IDLE: `start` -> latch `count_max`, clear `error`, clear stop_req -> ARM. `start` in any other state is ignored.
- ARM: `avg_restart`=1 for exactly one cycle -> WAIT_BUSY.
- WAIT_BUSY: wait for `avg_ready`==0 -> WAIT_READY.
- WAIT_READY: wait for `avg_ready`==1; on that cycle latch `avg_n_avg` into `n_avg` -> READOUT.
- READOUT: issue reads for indices 0..count_max_reg in order; data enters a FIFO of depth BRAM_LATENCY+2; a read is issued only when (in-flight + FIFO occupancy) < depth, so no data is ever dropped. `m_tlast` accompanies index count_max_reg. Transition to DONE on the handshake of the tlast beat.
- DONE: `done`=1 one cycle, `frame_count`+1 (wraps at 2^32). If `continuous` and no stop_req -> ARM, else IDLE.
- `stop` pulse in any non-IDLE state sets stop_req; current frame finishes readout normally.
- Timeout: a per-state cycle counter resets on entry to WAIT_BUSY/WAIT_READY; reaching `timeout_cycles` (nonzero) -> `error`=1, go to IDLE, no readout, no `done`.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: avg_restart=0, bram_en=0, bram_addr=0, m_tvalid=0, m_tlast=0, m_tdata=0, n_avg=0, busy=0, done=0, error=0, frame_count=0; FIFO emptied, state IDLE.
- `start` at cycle t -> `avg_restart` high at t+1 (registered), `busy` high at t+1.
- Read at cycle r -> word in FIFO at r+BRAM_LATENCY; `m_tvalid` asserted from FIFO non-empty, registered output.
- With `m_tready` held 1: one beat per cycle after initial latency of BRAM_LATENCY+1 cycles from READOUT entry; frame of count_max+1 beats.
- `m_tdata`/`m_tlast` stable while `m_tvalid`=1 and `m_tready`=0.
- count_max=0: single beat with `m_tlast`=1.
- `count_max` changes after start have no effect until the next start.
- Reset deassertion mid-frame: block restarts in IDLE; no partial stream resumes.

## Structure
- Shared package: state enum, FIFO depth constant (BRAM_LATENCY+2), address-shift constant (2).
- One sub-module: `averager_readout_fifo` (sync FIFO, parameterized depth/width, count output used for read credit).

## Test plan
- Single shot, count_max=7, m_tready=1, counter model drops ready 2 cycles after restart and raises it 40 later with n_avg=5 -> one restart pulse, 8 beats data=BRAM[0..7], tlast on beat 8, n_avg=5, done pulse, frame_count=1, busy back to 0.
- Backpressure: count_max=15, m_tready random 30% -> exactly 16 beats, in order, no duplicates, data stable while stalled.
- Continuous: continuous=1, stop pulsed during second frame's WAIT_READY -> exactly 2 frames streamed, frame_count=2, then IDLE.
- Timeout: timeout_cycles=100, avg_ready never drops -> error=1 at cycle 100 of WAIT_BUSY, no stream beats, no done; next start clears error.
- Edge: count_max=0 -> one beat with tlast; start pulsed during READOUT ignored (no second restart).
- Reset: aresetn asserted mid-READOUT -> all outputs at reset values next cycle, m_tvalid=0, fresh start works normally.
